// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector for an N-bit PATTERN (MSB first on the stream).
// Next-state table is derived from PATTERN at elaboration; a saturating counter tracks hits.
module seq_detect_moore #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int SW   = $clog2(N+1);
  localparam int NTBL = 1 << SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t S0 = '0;
  localparam state_t SN = state_t'(N);

  // Stream-order bit i of the pattern (i=0 is the first bit expected).
  function automatic int pat_bit(int i);
    logic [31:0] p;
    p = 32'(PATTERN);
    return int'((p >> (N-1-i)) & 32'd1);
  endfunction

  // Longest proper border of the whole pattern.
  function automatic int border();
    int  b;
    bit  ok;
    b = 0;
    for (int len = 1; len < N; len++) begin
      ok = 1'b1;
      for (int t = 0; t < len; t++)
        if (pat_bit(N-len+t) != pat_bit(t)) ok = 1'b0;
      if (ok) b = len;
    end
    return b;
  endfunction

  // KMP transition: from Sk consume xb; SN first collapses to its restart state.
  function automatic int delta(int k, int xb);
    int kk, j, idx, sb;
    bit ok;
    if (k > N)       return 0;
    if (k == N)      kk = OVERLAP ? border() : 0;
    else             kk = k;
    j = 0;
    for (int len = 1; len <= kk+1; len++) begin
      ok = 1'b1;
      for (int t = 0; t < len; t++) begin
        idx = kk + 1 - len + t;
        sb  = (idx == kk) ? xb : pat_bit(idx);
        if (sb != pat_bit(t)) ok = 1'b0;
      end
      if (ok) j = len;
    end
    return j;
  endfunction

  state_t nxt0 [NTBL];
  state_t nxt1 [NTBL];

  for (genvar k = 0; k < NTBL; k++) begin : g_tbl
    localparam state_t NX0 = state_t'(delta(k, 0));
    localparam state_t NX1 = state_t'(delta(k, 1));
    assign nxt0[k] = NX0;
    assign nxt1[k] = NX1;
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    // x is only looked at when en is high, so an undriven x during a stall is harmless
    if (en) state_d = x ? nxt1[state_q] : nxt0[state_q];
    inc = en && (state_d == SN);
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
      if (&cnt_d)           sat_d = 1'b1;
    end
  end

  assign z         = (state_q == SN);
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_moore.sv
// Randomized + directed bench for seq_detect_moore across four parameter sets,
// checked against a bit-history reference model.
module tb_seq_detect_moore;

  localparam int NI = 4;
  localparam int CFG_N   [NI] = '{4, 4, 5, 4};
  localparam int CFG_PAT [NI] = '{13, 13, 21, 13};
  localparam int CFG_OVL [NI] = '{1, 0, 1, 1};
  localparam int CFG_MAX [NI] = '{255, 255, 255, 3};

  logic clk = 1'b0;
  logic rst_n, en, x, clr;
  logic [NI-1:0] zv, sv;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;

  always #5 clk = ~clk;

  seq_detect_moore #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .z(zv[0]), .match_cnt(c0), .cnt_sat(sv[0]));
  seq_detect_moore #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .z(zv[1]), .match_cnt(c1), .cnt_sat(sv[1]));
  seq_detect_moore #(.N(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .z(zv[2]), .match_cnt(c2), .cnt_sat(sv[2]));
  seq_detect_moore #(.N(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr),
    .z(zv[3]), .match_cnt(c3), .cnt_sat(sv[3]));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw history of consumed bits since the last restart.
  int m_hist [NI];
  int m_hlen [NI];
  int m_z    [NI];
  int m_cnt  [NI];
  int m_sat  [NI];

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int get_cnt(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      default: return int'(c3);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_hist[i] = 0; m_hlen[i] = 0; m_z[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
    end
  endtask

  task automatic model_edge();
    int mask, hit;
    for (int i = 0; i < NI; i++) begin
      hit = 0;
      if (en) begin
        mask = (1 << CFG_N[i]) - 1;
        m_hist[i] = ((m_hist[i] << 1) | int'(x)) & 32'hFFFF;
        if (m_hlen[i] < 64) m_hlen[i]++;
        hit = (m_hlen[i] >= CFG_N[i]) && ((m_hist[i] & mask) == CFG_PAT[i]);
        if (hit && CFG_OVL[i] == 0) m_hlen[i] = 0;
        m_z[i] = hit;
      end
      if (clr) begin
        m_cnt[i] = 0; m_sat[i] = 0;
      end else begin
        if (hit && m_cnt[i] < CFG_MAX[i]) m_cnt[i]++;
        if (m_cnt[i] == CFG_MAX[i]) m_sat[i] = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s.u%0d.z", tag, i),   int'(zv[i]), m_z[i]);
      chk($sformatf("%s.u%0d.cnt", tag, i), get_cnt(i),  m_cnt[i]);
      chk($sformatf("%s.u%0d.sat", tag, i), int'(sv[i]), m_sat[i]);
    end
  endtask

  // Drive away from the edge, clock once, then compare 1 time unit after it.
  task automatic step(input logic e, input logic b, input logic c, input string tag);
    en = e; x = b; clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic feed(input int bits, input int len, input string tag);
    for (int k = len-1; k >= 0; k--) step(1'b1, 1'((bits >> k) & 1), 1'b0, tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; x = 1'b0; clr = 1'b0;
    model_reset();
    #22;
    check_all("reset");
    rst_n = 1'b1;

    // Overlap vs non-overlap on 1101101
    feed(7'b1101101, 7, "ovl");
    chk("ovl.cnt_u0", get_cnt(0), 2);
    chk("novl.cnt_u1", get_cnt(1), 1);
    async_reset("rst1");

    // Stall inside a partial match
    feed(3'b110, 3, "stall_pre");
    for (int k = 0; k < 5; k++) step(1'b0, 1'(k & 1), 1'b0, "stall");
    step(1'b1, 1'b1, 1'b0, "stall_end");
    chk("stall.z_u0", int'(zv[0]), 1);
    chk("stall.cnt_u0", get_cnt(0), 1);
    async_reset("rst2");

    // Border computation for 10101
    feed(7'b1010101, 7, "p10101");
    chk("p10101.cnt_u2", get_cnt(2), 2);
    async_reset("rst3");

    // Saturation on the 2-bit counter, then clr coincident with a match
    feed(4'b1101, 4, "sat1");
    chk("sat.cnt1", get_cnt(3), 1);
    feed(3'b101, 3, "sat2");
    chk("sat.cnt2", get_cnt(3), 2);
    feed(3'b101, 3, "sat3");
    chk("sat.cnt3", get_cnt(3), 3);
    chk("sat.flag3", int'(sv[3]), 1);
    feed(3'b101, 3, "sat4");
    chk("sat.cnt4", get_cnt(3), 3);
    feed(2'b10, 2, "clr_pre");
    step(1'b1, 1'b1, 1'b1, "clr_hit");
    chk("clr.cnt", get_cnt(3), 0);
    chk("clr.sat", int'(sv[3]), 0);
    chk("clr.z", int'(zv[3]), 1);
    async_reset("rst4");

    // Async reset while in S3 with a nonzero count
    feed(6'b110110, 6, "pre_s3");
    chk("pre_s3.cnt_u0", get_cnt(0), 1);
    async_reset("rst_s3");
    feed(3'b101, 3, "post_rst");
    chk("post_rst.z_u0", int'(zv[0]), 0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      step(1'(($urandom % 4) != 0), 1'($urandom % 2), 1'(($urandom % 40) == 0), "rnd");
      if (($urandom % 300) == 0) async_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
